// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
//   Interrupt controller sitting between the MotherBoard interrupt lines and
//   core0. Each raw line is synchronised, rising-edge detected and latched as
//   pending. Pending bits are filtered by a software mask. The lowest-index
//   eligible source is handed to the core, one at a time, through a
//   req/ack/eret handshake.
//
// Ports
//   clk            system clock, rising edge
//   reset          synchronous, active-high
//   i_interruption raw asynchronous interrupt lines (level, active-high)
//   i_reg_addr     MMIO word select: 0 PENDING (W1C), 1 MASK (RW), 2 STATUS (RO)
//   i_reg_we       MMIO write strobe
//   i_reg_wdata    MMIO write data
//   o_reg_rdata    MMIO read data, combinational from i_reg_addr
//   o_irq          registered interrupt request to the core
//   o_irq_cause    source index of the latched request
//   i_irq_ack      core has taken the exception (acts only in REQ)
//   i_eret         core returned from the handler (acts only in SERVICE)
// -----------------------------------------------------------------------------
module intr_ctrl #(
    parameter int N_SRC   = 5,
    parameter int SYNC_FF = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] i_interruption,
    input  logic [1:0]       i_reg_addr,
    input  logic             i_reg_we,
    input  logic [31:0]      i_reg_wdata,
    output logic [31:0]      o_reg_rdata,
    output logic             o_irq,
    output logic [2:0]       o_irq_cause,
    input  logic             i_irq_ack,
    input  logic             i_eret
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // After reset the synchroniser refills from zero, so a line that is
    // already high would look like a fresh rising edge. Edge capture stays
    // suppressed until the chain and the delay flop hold real samples, which
    // means a line held high across reset must go low before it re-arms.
    localparam int              SETTLE     = SYNC_FF + 1;
    localparam int              CW         = $clog2(SETTLE + 1);
    localparam logic [CW-1:0]   SETTLE_CNT = CW'(SETTLE);

    logic [SYNC_FF-1:0][N_SRC-1:0] sync_reg;
    logic [N_SRC-1:0]              delayed_reg;
    logic [N_SRC-1:0]              edge_reg;
    logic [CW-1:0]                 settle_reg;
    logic                          settling;

    logic [N_SRC-1:0] pending_reg;
    logic [N_SRC-1:0] pending_next;
    logic [N_SRC-1:0] mask_reg;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] w1c;
    logic [N_SRC-1:0] cause_sel;
    logic [N_SRC-1:0] ack_clr;

    logic [1:0] state_reg;
    logic [2:0] cause_reg;
    logic [2:0] winner;
    logic       irq_reg;
    logic       ack_take;
    logic       w1c_hit;

    logic unused_wdata;
    assign unused_wdata = ^i_reg_wdata[31:N_SRC];

    assign settling = (settle_reg != SETTLE_CNT);

    // Input path: synchroniser, one delay flop, registered rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg    <= '0;
            delayed_reg <= '0;
            edge_reg    <= '0;
            settle_reg  <= '0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_FF-2:0], i_interruption};
            delayed_reg <= sync_reg[SYNC_FF-1];
            edge_reg    <= settling ? '0 : (sync_reg[SYNC_FF-1] & ~delayed_reg);
            if (settling) begin
                settle_reg <= settle_reg + CW'(1);
            end
        end
    end

    assign w1c      = (i_reg_we && i_reg_addr == 2'd0) ? i_reg_wdata[N_SRC-1:0] : '0;
    assign ack_take = (state_reg == ST_REQ) && i_irq_ack;
    assign eligible = pending_reg & mask_reg;
    assign w1c_hit  = |(w1c & cause_sel);

    // Per-source pending update; a new edge wins over any clear in the same cycle.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign cause_sel[gi]    = (cause_reg == 3'(gi));
            assign ack_clr[gi]      = ack_take & cause_sel[gi];
            assign pending_next[gi] = edge_reg[gi] |
                                      (pending_reg[gi] & ~w1c[gi] & ~ack_clr[gi]);
        end
    endgenerate

    // Fixed priority: bit 0 highest.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_reg <= '0;
            mask_reg    <= '0;
        end else begin
            pending_reg <= pending_next;
            if (i_reg_we && i_reg_addr == 2'd1) begin
                mask_reg <= i_reg_wdata[N_SRC-1:0];
            end
        end
    end

    // Handshake FSM. The cause is latched on entry to REQ and held until the
    // next request so the core and STATUS see a stable value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cause_reg <= '0;
            irq_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|eligible) begin
                        state_reg <= ST_REQ;
                        cause_reg <= winner;
                        irq_reg   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    // An ack in the same cycle as a W1C of the cause wins.
                    if (i_irq_ack) begin
                        state_reg <= ST_SERVICE;
                        irq_reg   <= 1'b0;
                    end else if (w1c_hit) begin
                        state_reg <= ST_IDLE;
                        irq_reg   <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (i_eret) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    irq_reg   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        o_reg_rdata = '0;
        case (i_reg_addr)
            2'd0: o_reg_rdata[N_SRC-1:0] = pending_reg;
            2'd1: o_reg_rdata[N_SRC-1:0] = mask_reg;
            2'd2: begin
                o_reg_rdata[1:0] = state_reg;
                o_reg_rdata[6:4] = cause_reg;
            end
            default: o_reg_rdata = '0;
        endcase
    end

    assign o_irq       = irq_reg;
    assign o_irq_cause = cause_reg;

endmodule
